// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, mid-bit sampling.
// Flags a bad stop bit through frame_err while still delivering the word.
module uart_rx #(
    parameter int N_BITS  = 8,
    parameter int SB_TICK = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              s_tick,
    output logic [N_BITS-1:0] dout,
    output logic              rx_done_tick,
    output logic              frame_err
);

    localparam int NW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        s_q, s_d;
    logic [NW-1:0]     n_q, n_d;
    logic [N_BITS-1:0] b_q, b_d;
    logic [N_BITS-1:0] dout_d;
    logic              done_d;
    logic              fe_d;
    logic              rx_m;
    logic              rx_s;
    logic [N_BITS:0]   b_sh;

    // Line idles high, so the synchronizer comes out of reset at 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            s_q          <= '0;
            n_q          <= '0;
            b_q          <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            b_q          <= b_d;
            dout         <= dout_d;
            rx_done_tick <= done_d;
            frame_err    <= fe_d;
        end
    end

    assign b_sh = {rx_s, b_q};

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout;
        done_d  = 1'b0;
        fe_d    = frame_err;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = b_sh[N_BITS:1];
                        if (n_q == NW'(N_BITS - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        dout_d  = b_q;
                        fe_d    = ~rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
